// File: rtl/pbd_arbiter_if.sv
// Request/grant bundle between two requesters and the arbiter that drives
// the downstream 1-to-2 decoder (select a, enable e).
interface pbd_arbiter_if;
  logic req0;
  logic req1;
  logic a;
  logic e;
  logic busy;

  modport master (output req0, output req1, input a, input e, input busy);
  modport slave  (input req0, input req1, output a, output e, output busy);
endinterface

// File: rtl/pbd_arbiter.sv
// Two-channel round-robin arbiter driving a 1-to-2 decoder: a grant lasts
// at most HOLD_CYCLES cycles, and grants are separated by GAP_CYCLES dead cycles.
module pbd_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic          clk,
  input  logic          rst,
  pbd_arbiter_if.slave  bus,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] GAP_LOAD  = 3'(GAP_CYCLES - 1);

  state_t     state;
  logic       a_q;
  logic       e_q;
  logic       busy_q;
  logic       last_owner;
  logic [3:0] hold_cnt;
  logic [2:0] gap_cnt;

  logic any_req;
  logic pick;
  logic owner_req;

  // On a tie the channel that did not own the previous grant wins.
  assign any_req   = bus.req0 | bus.req1;
  assign pick      = (bus.req0 & bus.req1) ? ~last_owner : bus.req1;
  assign owner_req = a_q ? bus.req1 : bus.req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= 1'b0;
      e_q        <= 1'b0;
      busy_q     <= 1'b0;
      last_owner <= 1'b1;
      hold_cnt   <= 4'd0;
      gap_cnt    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= GRANT;
            a_q      <= pick;
            e_q      <= 1'b1;
            busy_q   <= 1'b1;
            hold_cnt <= HOLD_LOAD;
          end
        end
        GRANT: begin
          // a stays frozen here so the decoder never sees a select change while enabled.
          if (hold_cnt == 4'd0 || !owner_req) begin
            state      <= GAP;
            e_q        <= 1'b0;
            last_owner <= a_q;
            gap_cnt    <= GAP_LOAD;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 3'd0) begin
            if (any_req) begin
              state    <= GRANT;
              a_q      <= pick;
              e_q      <= 1'b1;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          e_q    <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a    = a_q;
  assign bus.e    = e_q;
  assign bus.busy = busy_q;
  assign fsm_state = state;

endmodule

// File: doc/pbd_arbiter.md
PBD_ARBITER -- requirements
Module: pbd_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, meaning the maximum number of consecutive cycles one grant stays active (legal 1..15).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, meaning the number of dead cycles with e=0 between any two grants (legal 1..7).
REQ-003 The block SHALL run on one clock and use a synchronous, active-high reset.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port req0: input, 1 bit, channel-0 request, level-sensitive.
REQ-007 Port req1: input, 1 bit, channel-1 request, level-sensitive.
REQ-008 Port a: output, 1 bit, select to the downstream 1-to-2 decoder (0 = y0, 1 = y1).
REQ-009 Port e: output, 1 bit, enable to the downstream decoder; high only while a grant is active.
REQ-010 Port busy: output, 1 bit, high in GRANT and GAP states.

Function
REQ-011 The outputs a, e and busy SHALL be driven directly from flops, with no combinational path from req0/req1.
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-013 In IDLE with no request sampled, the FSM SHALL stay in IDLE with e=0, and a SHALL hold its last value.
REQ-014 In IDLE, if only reqN is sampled high, the next cycle SHALL be GRANT with a=N and e=1 (one-cycle request-to-enable latency).
REQ-015 In IDLE, if both requests are sampled high, the grant SHALL go to the channel not equal to last_owner (round-robin).
REQ-016 On GRANT entry, the hold counter SHALL load HOLD_CYCLES-1.
REQ-017 In GRANT, the hold counter SHALL decrement once per cycle.
REQ-018 GRANT SHALL exit to GAP at the edge where the counter equals 0 or the owner's request is sampled low, whichever occurs first.
REQ-019 e SHALL therefore be high for at least 1 and at most HOLD_CYCLES cycles per grant.
REQ-020 On GRANT exit, last_owner SHALL be set to a, and e SHALL fall at that edge.
REQ-021 During GRANT, a SHALL not change, so the downstream decoder sees no select glitch while enabled.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with e=0 and a held.
REQ-023 At the end of GAP, requests SHALL be arbitrated as in IDLE, going directly to GRANT if any request is high and to IDLE otherwise.
REQ-024 A channel holding its request continuously SHALL never starve the other: with both requests held high, grants SHALL alternate 0,1,0,1...
REQ-025 A request pulse that is asserted and deasserted entirely within GRANT or GAP SHALL be ignored (not queued).
REQ-026 e and a SHALL only change on rising clk edges, and e=1 SHALL never coincide with an a transition.

Reset
REQ-027 When rst is sampled high, the block SHALL enter IDLE at that edge with e=0, a=0, busy=0, last_owner=1 and the hold counter at 0.
REQ-028 rst SHALL override all activity, including a grant or gap in progress; e SHALL drop at that edge.
REQ-029 After rst is released, the first tie SHALL be granted to channel 0.
REQ-030 Requests sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-031 Reset then single request: rst 2 cycles; req1=1 held -> e=1, a=1 one cycle after first sample, for 4 cycles; then e=0 for 1 cycle; then re-granted to a=1.
REQ-032 Tie after reset: req0=req1=1 held -> grant sequence a=0(4 cycles), gap, a=1(4 cycles), gap, a=0; e=0 in every gap cycle.
REQ-033 Early release: req0 high 2 cycles, then low -> e high exactly 2 cycles; busy low after the gap with no further grant.
REQ-034 Reset mid-grant: assert rst in the 2nd GRANT cycle -> e=0, a=0, busy=0 at that edge; a later tie is granted to channel 0.
REQ-035 Parameter corners: HOLD_CYCLES=1, GAP_CYCLES=3 with both requests held -> e pattern 1,0,0,0 repeating, a alternating per grant and never changing while e=1.
